// File: rtl/ram_burst_pkg.sv
// Shared types and defaults for the RAM burst controller.
package ram_burst_pkg;

   localparam int unsigned DefAddrSize = 10;
   localparam int unsigned DefWordSize = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWrite = 2'd1,
      StRead  = 2'd2
   } state_e;

endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Command, write-stream, read-stream and RAM pin bundle of the burst controller.
interface ram_burst_ctrl_if
   import ram_burst_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = DefAddrSize,
   parameter int unsigned WORD_SIZE = DefWordSize
);

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic                 cmd_wr;
   logic [ADDR_SIZE-1:0] cmd_addr;
   logic [ADDR_SIZE-1:0] cmd_len;
   logic [WORD_SIZE-1:0] wdata;
   logic                 wdata_valid;
   logic                 wdata_ready;
   logic [WORD_SIZE-1:0] rdata;
   logic                 rdata_valid;
   logic                 rdata_ready;
   logic                 busy;
   logic [ADDR_SIZE-1:0] ram_addr;
   logic [WORD_SIZE-1:0] ram_data_in;
   logic                 ram_wr;
   logic                 ram_cs;
   logic [WORD_SIZE-1:0] ram_data_out;

   // Controller side
   modport slave (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata, wdata_valid, rdata_ready,
             ram_data_out,
      output cmd_ready, wdata_ready, rdata, rdata_valid, busy, ram_addr, ram_data_in,
             ram_wr, ram_cs
   );

   // Host / RAM side
   modport master (
      output cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata, wdata_valid, rdata_ready,
             ram_data_out,
      input  cmd_ready, wdata_ready, rdata, rdata_valid, busy, ram_addr, ram_data_in,
             ram_wr, ram_cs
   );

endinterface

// File: rtl/ram_burst_rd_reg.sv
// Single-entry read output register with valid/ready handshake.
module ram_burst_rd_reg
   import ram_burst_pkg::*;
#(
   parameter int unsigned WORD_SIZE = DefWordSize
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [WORD_SIZE-1:0] data_i,
   input  logic                 ready_i,
   output logic [WORD_SIZE-1:0] data_o,
   output logic                 valid_o,
   output logic                 can_load_o
);

   logic [WORD_SIZE-1:0] data_q;
   logic                 valid_q;

   // Room for a new word when empty or when the held word leaves this cycle
   assign can_load_o = !valid_q || ready_i;
   assign data_o     = data_q;
   assign valid_o    = valid_q;

   // Load a new word, otherwise drop valid once the consumer takes the held word
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of an async-read, level-write single-port RAM.
module ram_burst_ctrl
   import ram_burst_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = DefAddrSize,
   parameter int unsigned WORD_SIZE = DefWordSize
) (
   input logic             clk,
   input logic             rst,
   ram_burst_ctrl_if.slave bus
);

   localparam logic [ADDR_SIZE-1:0] AddrOne = ADDR_SIZE'(1);

   state_e               state_q;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [ADDR_SIZE-1:0] count_q;
   logic [WORD_SIZE-1:0] wdata_q;
   logic                 wr_q;
   logic                 cs_q;
   logic                 busy_q;

   logic                 cmd_ready;
   logic                 wdata_ready;
   logic                 rd_can_load;
   logic                 rd_load;
   logic                 rd_valid;
   logic [WORD_SIZE-1:0] rd_data;

   // A pending read word blocks new commands so it cannot be overtaken
   assign cmd_ready   = (state_q == StIdle) && !rd_valid;
   // Only one word per wr pulse; the pulse cycle itself accepts nothing
   assign wdata_ready = (state_q == StWrite) && !wr_q;
   assign rd_load     = (state_q == StRead) && rd_can_load;

   assign bus.cmd_ready   = cmd_ready;
   assign bus.wdata_ready = wdata_ready;
   assign bus.busy        = busy_q;
   assign bus.ram_addr    = addr_q;
   assign bus.ram_data_in = wdata_q;
   assign bus.ram_wr      = wr_q;
   assign bus.ram_cs      = cs_q;
   assign bus.rdata       = rd_data;
   assign bus.rdata_valid = rd_valid;

   ram_burst_rd_reg #(
      .WORD_SIZE (WORD_SIZE)
   ) u_rd_reg (
      .clk        (clk),
      .rst        (rst),
      .load_i     (rd_load),
      .data_i     (bus.ram_data_out),
      .ready_i    (bus.rdata_ready),
      .data_o     (rd_data),
      .valid_o    (rd_valid),
      .can_load_o (rd_can_load)
   );

   // Burst FSM: command capture, write pulse sequencing and address/count stepping
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         count_q <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         cs_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.cmd_valid && cmd_ready) begin
                  addr_q  <= bus.cmd_addr;
                  count_q <= bus.cmd_len;
                  cs_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= bus.cmd_wr ? StWrite : StRead;
               end
            end
            StWrite: begin
               if (wr_q) begin
                  // Pulse ends first; address moves only once wr is low again
                  wr_q <= 1'b0;
                  if (count_q == '0) begin
                     state_q <= StIdle;
                     cs_q    <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     addr_q  <= addr_q + AddrOne;
                     count_q <= count_q - AddrOne;
                  end
               end else if (bus.wdata_valid) begin
                  wdata_q <= bus.wdata;
                  wr_q    <= 1'b1;
               end
            end
            StRead: begin
               if (rd_can_load) begin
                  if (count_q == '0) begin
                     state_q <= StIdle;
                     cs_q    <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     addr_q  <= addr_q + AddrOne;
                     count_q <= count_q - AddrOne;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               wr_q    <= 1'b0;
               cs_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
- Burst controller sitting directly upstream of the asynchronous-read, level-triggered-write single-port RAM.
- Accepts one command at a time: start address, length, direction.
- Streams write words into the RAM, or streams read words out, using valid/ready handshakes.
- Drives the RAM's addr/data_in/wr/cs pins so every write is a clean wr pulse with address and data held stable around it.

Parameters:
- ADDR_SIZE, 10, RAM address width; also burst-length field width.
- WORD_SIZE, 8, RAM word width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  controller can accept a command.
- cmd_wr  input  1  1 = write burst, 0 = read burst.
- cmd_addr  input  ADDR_SIZE  burst start address.
- cmd_len  input  ADDR_SIZE  burst length minus one (0 means 1 word, max means 2^ADDR_SIZE words).
- wdata  input  WORD_SIZE  write data word.
- wdata_valid  input  1  write word offered.
- wdata_ready  output  1  write word accepted this cycle when high with wdata_valid.
- rdata  output  WORD_SIZE  read data word.
- rdata_valid  output  1  rdata holds a word.
- rdata_ready  input  1  consumer takes rdata.
- busy  output  1  burst in progress (state != IDLE).
- ram_addr  output  ADDR_SIZE  to RAM addr.
- ram_data_in  output  WORD_SIZE  to RAM data_in.
- ram_wr  output  1  to RAM wr.
- ram_cs  output  1  to RAM cs.
- ram_data_out  input  WORD_SIZE  from RAM data_out (combinational read).

Behaviour:
- Clock and reset: single clock clk; synchronous active-high rst, sampled on the rising edge.
- All outputs are registered except cmd_ready and wdata_ready, which decode from registered state.
- Reset values:
  - state IDLE
  - ram_addr 0, ram_data_in 0, ram_wr 0, ram_cs 0
  - rdata 0, rdata_valid 0, busy 0
  - internal remaining-count 0
- rst mid-burst abandons the burst immediately. No further RAM writes occur; a partially written burst is left as-is.
- States: IDLE, WRITE, READ.
- IDLE:
  - cmd_ready = !rdata_valid.
  - On cmd_valid && cmd_ready: load ram_addr = cmd_addr and count = cmd_len, set ram_cs = 1, then go to WRITE if cmd_wr, else READ.
- WRITE (two cycles per word, because the RAM is level-triggered):
  - wdata_ready = !ram_wr.
  - On wdata_valid && wdata_ready: register ram_data_in = wdata and ram_wr = 1. ram_addr is unchanged.
  - Next cycle: ram_wr = 0.
    - If count == 0: go to IDLE and drop ram_cs.
    - Else: ram_addr += 1 (mod 2^ADDR_SIZE) and count -= 1.
  - ram_addr and ram_data_in are never changed while ram_wr = 1.
  - Max throughput is 1 word per 2 cycles. Stalls on wdata_valid are unbounded.
- READ:
  - Output register loads when (!rdata_valid || rdata_ready).
  - On load: rdata = ram_data_out (value at the current ram_addr) and rdata_valid = 1.
    - If count == 0: go to IDLE and drop ram_cs.
    - Else: ram_addr += 1 and count -= 1.
  - Throughput is 1 word per cycle when rdata_ready is held high.
  - Read latency: first rdata_valid appears 2 cycles after command acceptance.
- rdata_valid clears on rdata_ready when no new load occurs. This covers the last word being drained in IDLE.
- Address wrap: addr 2^ADDR_SIZE-1 increments to 0 with no error.
- Command handling: cmd_valid is ignored while busy. A new command is not accepted until the previous read's final word is consumed.
- wdata_valid is ignored outside WRITE. ram_wr is never 1 outside WRITE.

Decomposition:
- Package ram_burst_pkg holds:
  - the state encoding constants: IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2
  - default ADDR_SIZE and WORD_SIZE
- One natural sub-module: ram_burst_rd_reg, the single-entry read output register with valid/ready.
- The FSM and address/count logic stay in the top.

Test Plan:
- Write burst, addr 0x010, len 3, data A0..A3 with wdata_valid held high:
  - wdata_ready pulses every 2nd cycle.
  - ram_wr shows 4 single-cycle pulses at addr 0x010..0x013.
  - RAM then holds A0..A3; busy falls after the last pulse.
- Read back 0x010, len 3, with rdata_ready held high:
  - rdata = A0, A1, A2, A3 on 4 consecutive cycles.
  - First word arrives 2 cycles after the command handshake.
- Read with backpressure (rdata_ready low for 5 cycles mid-burst):
  - rdata holds steady; ram_addr does not advance.
  - No word is lost or duplicated.
- Wrap: write addr 0x3FE, len 3, data 11, 22, 33, 44:
  - Words land at 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-write after 2 words (rst high for 1 cycle):
  - All outputs return to reset values next edge.
  - Only the first 2 words are written; cmd_ready = 1 afterwards.
- Command during busy, and single-word burst:
  - cmd_valid asserted during a read burst is not accepted (cmd_ready = 0).
  - After drain, len 0 write of 5A at 0x200 produces exactly one ram_wr pulse.
